// File: rtl/stepdown_deadtime_sequencer.sv
// Step-down gate sequencer: turns one drive request into complementary
// high/low-side enables with programmable dead time and fault latching.
module stepdown_deadtime_sequencer #(
  parameter int DT_W   = 6,
  parameter int MIN_ON = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            CELSUB,
  input  logic            en,
  input  logic            drv_req,
  input  logic            fault_n,
  input  logic [DT_W-1:0] dt_lh,
  input  logic [DT_W-1:0] dt_hl,
  output logic            hs_en,
  output logic            ls_en,
  output logic [2:0]      state,
  output logic            fault_lat
);

  localparam int OW = $clog2(MIN_ON + 1);
  localparam logic [OW-1:0] MIN_C = OW'(MIN_ON);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LS_ON = 3'd1,
    DT_LH = 3'd2,
    HS_ON = 3'd3,
    DT_HL = 3'd4,
    FAULT = 3'd5
  } st_e;

  st_e            st, nxt;
  logic           s1, req_s;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic [DT_W-1:0] lh1, hl1;
  logic [OW-1:0]  on_cnt, on_nxt;
  logic           lat_nxt;
  logic           unused_pwr;

  // Supply pins carry no logic.
  assign unused_pwr = ^{CELV, CELG, CELSUB};

  assign lh1   = (dt_lh == '0) ? DT_W'(1) : dt_lh;
  assign hl1   = (dt_hl == '0) ? DT_W'(1) : dt_hl;
  assign state = st;

  always_comb begin
    nxt     = st;
    cnt_nxt = cnt;
    on_nxt  = on_cnt;
    lat_nxt = fault_lat;
    if (!fault_n) begin
      nxt     = FAULT;
      lat_nxt = 1'b1;
    end else if (st == FAULT) begin
      if (!en) begin
        nxt     = IDLE;
        lat_nxt = 1'b0;
      end
    end else if (!en) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: nxt = LS_ON;
        LS_ON: begin
          if (req_s) begin
            nxt     = DT_LH;
            cnt_nxt = lh1;
          end
        end
        DT_LH: begin
          if (!req_s) begin
            nxt = LS_ON;
          end else if (cnt == DT_W'(1)) begin
            nxt    = HS_ON;
            on_nxt = OW'(1);
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        HS_ON: begin
          if (!req_s && on_cnt >= MIN_C) begin
            nxt     = DT_HL;
            cnt_nxt = hl1;
          end else if (on_cnt < MIN_C) begin
            on_nxt = on_cnt + OW'(1);
          end
        end
        DT_HL: begin
          if (cnt == DT_W'(1)) begin
            nxt = LS_ON;
          end else if (req_s) begin
            nxt     = DT_LH;
            cnt_nxt = lh1;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Enables decode from the next state so they switch with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      req_s     <= 1'b0;
      st        <= IDLE;
      cnt       <= '0;
      on_cnt    <= '0;
      hs_en     <= 1'b0;
      ls_en     <= 1'b0;
      fault_lat <= 1'b0;
    end else begin
      s1        <= drv_req;
      req_s     <= s1;
      st        <= nxt;
      cnt       <= cnt_nxt;
      on_cnt    <= on_nxt;
      hs_en     <= (nxt == HS_ON);
      ls_en     <= (nxt == LS_ON);
      fault_lat <= lat_nxt;
    end
  end

endmodule
